// File: rtl/frac_div_meter.sv
// Fractional-divider period meter: counts clk_in cycles between rising edges of
// an asynchronous divided clock over WIN periods, reporting total, min and max.
module frac_div_meter #(
  parameter int unsigned WIN   = 10,
  parameter int unsigned PER_W = 8,
  parameter int unsigned TOT_W = 16
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sig_in,
  output logic             busy,
  output logic             done_vld,
  output logic [TOT_W-1:0] total,
  output logic [PER_W-1:0] min_per,
  output logic [PER_W-1:0] max_per,
  output logic             timeout
);

  localparam int unsigned IdxW = $clog2(WIN + 1);
  localparam logic [IdxW-1:0]  WinIdx = IdxW'(WIN);
  localparam logic [PER_W-1:0] PerMax = {PER_W{1'b1}};
  localparam logic [PER_W-1:0] PerOne = PER_W'(1);

  typedef enum logic [1:0] {StIdle, StArm, StMeas, StDone} state_e;

  state_e           state_q, state_d;
  logic             sync1_q, sync2_q, hist_q;
  logic             sig_rise;
  logic [PER_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [TOT_W-1:0] acc_q, acc_d;
  logic [PER_W-1:0] min_q, min_d, max_q, max_d;
  logic             to_set;

  logic [TOT_W-1:0] total_q;
  logic [PER_W-1:0] min_per_q, max_per_q;
  logic             timeout_q;

  // Two-flop synchroniser plus history flop for rising-edge detection.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= sig_in;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign sig_rise = sync2_q & ~hist_q;
  assign cnt_inc  = cnt_q + PerOne;

  // Next-state and datapath updates for the measurement FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    min_d   = min_q;
    max_d   = max_q;
    to_set  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // An edge coincident with start is deliberately not taken as the first edge.
        if (start) begin
          state_d = StArm;
          cnt_d   = '0;
          idx_d   = '0;
          acc_d   = '0;
          min_d   = PerMax;
          max_d   = '0;
        end
      end
      StArm: begin
        if (sig_rise) begin
          state_d = StMeas;
          cnt_d   = PerOne;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == PerMax) begin
            state_d = StDone;
            to_set  = 1'b1;
          end
        end
      end
      StMeas: begin
        if (sig_rise) begin
          acc_d = acc_q + TOT_W'(cnt_q);
          if (cnt_q < min_q) min_d = cnt_q;
          if (cnt_q > max_q) max_d = cnt_q;
          cnt_d = PerOne;
          idx_d = idx_q + IdxW'(1);
          if (idx_d == WinIdx) state_d = StDone;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == PerMax) begin
            state_d = StDone;
            to_set  = 1'b1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and internal accumulator registers.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      min_q   <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      min_q   <= min_d;
      max_q   <= max_d;
    end
  end

  // Results load on entry to DONE so they are valid alongside done_vld.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      total_q   <= '0;
      min_per_q <= '0;
      max_per_q <= '0;
      timeout_q <= 1'b0;
    end else if (state_d == StDone) begin
      total_q   <= acc_d;
      min_per_q <= min_d;
      max_per_q <= max_d;
      timeout_q <= to_set;
    end
  end

  assign busy     = (state_q == StArm) || (state_q == StMeas);
  assign done_vld = (state_q == StDone);
  assign total    = total_q;
  assign min_per  = min_per_q;
  assign max_per  = max_per_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_frac_div_meter.sv
// Directed bench for frac_div_meter with hand-computed expected results.
module tb_frac_div_meter;

  logic        clk_in = 1'b0;
  logic        rst_n  = 1'b0;
  logic        start  = 1'b0;
  logic        sig_in = 1'b0;
  logic        busy;
  logic        done_vld;
  logic [15:0] total;
  logic [7:0]  min_per;
  logic [7:0]  max_per;
  logic        timeout;

  int n_vec  = 0;
  int n_err  = 0;
  int done_cnt = 0;
  int pq[$];

  frac_div_meter #(
    .WIN  (10),
    .PER_W(8),
    .TOT_W(16)
  ) u_dut (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .start   (start),
    .sig_in  (sig_in),
    .busy    (busy),
    .done_vld(done_vld),
    .total   (total),
    .min_per (min_per),
    .max_per (max_per),
    .timeout (timeout)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) if (done_vld) done_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Rising edge now, then one further rising edge after each period in pq (high 2 cycles).
  task automatic run_wave();
    sig_in = 1'b1;
    foreach (pq[i]) begin
      tick(2);
      sig_in = 1'b0;
      tick(pq[i] - 2);
      sig_in = 1'b1;
    end
    tick(2);
    sig_in = 1'b0;
  endtask

  task automatic fill(input int n, input int p);
    pq.delete();
    repeat (n) pq.push_back(p);
  endtask

  // Waits on negedges for done_vld; cyc is the number of negedges seen.
  task automatic wait_done(input string tag, input int budget, output int cyc);
    bit found = 1'b0;
    cyc = 0;
    while (!found && cyc < budget) begin
      @(negedge clk_in);
      cyc++;
      if (done_vld) found = 1'b1;
    end
    check_eq({tag, ".done_seen"}, {31'd0, found}, 32'd1);
  endtask

  task automatic check_res(input string tag, input int tot, input int mn, input int mx,
                           input int to);
    check_eq({tag, ".total"}, {16'd0, total}, tot);
    check_eq({tag, ".min"}, {24'd0, min_per}, mn);
    check_eq({tag, ".max"}, {24'd0, max_per}, mx);
    check_eq({tag, ".timeout"}, {31'd0, timeout}, to);
  endtask

  initial begin
    int cyc;
    int dc0;

    // Reset state
    tick(3);
    check_res("reset", 0, 0, 0, 0);
    check_eq("reset.busy", {31'd0, busy}, 0);
    check_eq("reset.done", {31'd0, done_vld}, 0);
    rst_n = 1'b1;
    tick(2);

    // Fractional 8.7 pattern
    pq = '{8, 9, 9, 8, 9, 9, 8, 9, 9, 9};
    dc0 = done_cnt;
    pulse_start();
    tick(3);
    check_eq("frac.busy_arm", {31'd0, busy}, 1);
    run_wave();
    wait_done("frac", 50, cyc);
    check_res("frac", 87, 8, 9, 0);
    tick(3);
    check_eq("frac.busy_after", {31'd0, busy}, 0);
    check_eq("frac.done_once", done_cnt - dc0, 1);

    // Fixed period 5, twice; results hold between runs
    fill(10, 5);
    pulse_start();
    tick(2);
    run_wave();
    wait_done("fix1", 50, cyc);
    check_res("fix1", 50, 5, 5, 0);
    tick(5);
    check_eq("fix.hold_total", {16'd0, total}, 50);
    pulse_start();
    tick(3);
    check_eq("fix.hold_busy", {31'd0, busy}, 1);
    check_eq("fix.hold_run_total", {16'd0, total}, 50);
    check_eq("fix.hold_run_min", {24'd0, min_per}, 5);
    run_wave();
    wait_done("fix2", 50, cyc);
    check_res("fix2", 50, 5, 5, 0);
    tick(3);

    // Stuck low: done exactly 255 cycles after entering ARM
    pulse_start();
    wait_done("stuck", 300, cyc);
    check_eq("stuck.latency", cyc - 1, 255);
    check_res("stuck", 0, 255, 0, 1);
    tick(3);

    // Stall after 4 periods of 6
    fill(4, 6);
    pulse_start();
    tick(2);
    run_wave();
    wait_done("stall", 400, cyc);
    check_res("stall", 24, 6, 6, 1);
    tick(3);

    // start pulsed during MEAS has no effect
    fill(10, 4);
    dc0 = done_cnt;
    pulse_start();
    tick(2);
    fork
      run_wave();
      begin
        tick(20);
        pulse_start();
      end
    join
    wait_done("ctl", 50, cyc);
    check_res("ctl", 40, 4, 4, 0);
    tick(20);
    check_eq("ctl.done_once", done_cnt - dc0, 1);
    check_eq("ctl.busy_after", {31'd0, busy}, 0);

    // start coincident with a detected edge; that edge is not the first edge
    sig_in = 1'b1;
    tick(2);
    pulse_start();
    sig_in = 1'b0;
    tick(1);
    fill(10, 6);
    run_wave();
    wait_done("coin", 50, cyc);
    check_res("coin", 60, 6, 6, 0);
    tick(3);

    // Reset mid-MEAS: outputs clear, no done pulse, then a clean run
    fill(3, 7);
    dc0 = done_cnt;
    pulse_start();
    tick(2);
    run_wave();
    tick(2);
    check_eq("rst.busy_meas", {31'd0, busy}, 1);
    rst_n = 1'b0;
    tick(2);
    check_res("rst", 0, 0, 0, 0);
    check_eq("rst.busy", {31'd0, busy}, 0);
    rst_n = 1'b1;
    tick(10);
    check_eq("rst.no_done", done_cnt - dc0, 0);
    fill(10, 7);
    pulse_start();
    tick(2);
    run_wave();
    wait_done("post_rst", 50, cyc);
    check_res("post_rst", 70, 7, 7, 0);
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/frac_div_meter.md
Name: frac_div_meter

Overview:
- Measuring end of the fractional clock dividers: counts clk_in cycles between rising edges of a divided clock (sig_in) over a window of WIN periods.
- Reports total cycles, shortest period and longest period, so an average ratio such as 8.7 (total 87 over 10 periods, min 8, max 9) is checked in hardware.
- Sits beside the divider as a self-check or monitor block; sig_in may be asynchronous to clk_in.

Parameters:
- WIN, 10, number of sig_in periods per measurement (>=1)
- PER_W, 8, width of per-period counter and min/max outputs; also sets the timeout
- TOT_W, 16, width of total accumulator; must hold WIN*(2^PER_W-1)

Ports:
- clk_in  input  1  measurement clock, all logic on its rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle request to begin a measurement
- sig_in  input  1  divided clock under test; treated as asynchronous
- busy  output  1  high while a measurement is armed or running
- done_vld  output  1  one-cycle pulse when results update
- total  output  TOT_W  sum of the WIN measured periods, in clk_in cycles
- min_per  output  PER_W  shortest measured period
- max_per  output  PER_W  longest measured period
- timeout  output  1  last measurement aborted because no edge arrived in time

Behaviour:
- Reset values:
  - All outputs are 0; the FSM is in IDLE; the counters and the synchroniser are 0.
  - Reset asserted mid-measurement aborts the measurement with no done_vld pulse.
- Input path:
  - sig_in passes through a 2-flop synchroniser plus one history flop.
  - A rising edge is detected when the synchronised value is 1 and the history flop is 0.
  - Detection latency is 3 clk_in cycles, fixed, so period measurement is unaffected.
- FSM states: IDLE, ARM, MEAS, DONE.
  - IDLE: on start go to ARM. Clear the internal accumulator, the period counter and the period index. Set internal min to all-ones and internal max to 0.
  - ARM: wait for the first detected edge. On that edge go to MEAS and load the period counter with 1. Otherwise increment the period counter.
  - MEAS, no edge: increment the period counter.
  - MEAS, on edge:
    - The captured period is the current period counter value, which equals the clk_in cycles since the previous edge.
    - Add the period to the accumulator and update min/max.
    - Reload the counter with 1 and increment the period index.
    - When the index reaches WIN, go to DONE.
  - Timeout: in ARM or MEAS, if the period counter reaches 2^PER_W-1 with no edge, go to DONE with timeout set.
  - DONE (1 cycle):
    - Register total, min_per and max_per from the internal values, and set timeout to 0 or 1.
    - done_vld=1 for this cycle only; next state IDLE.
    - On timeout, total, min_per and max_per hold the partial values (min all-ones if no period completed).
- busy=1 in ARM and MEAS, 0 in IDLE and DONE.
- start is ignored in ARM, MEAS and DONE; it is not queued.
- An edge detected in the same cycle as start in IDLE is not the first edge; ARM waits for the next one.
- Results hold their values until the next DONE. A new start does not clear the outputs.
- Arithmetic is unsigned. Given the TOT_W rule the accumulator never wraps, and period values never exceed 2^PER_W-2.

Test Plan:
- Fractional pattern: sig_in drives 10 periods mixing 3 periods of 8 cycles and 7 of 9 cycles (87 cycles total), then start -> done_vld once, total=87, min_per=8, max_per=9, timeout=0, busy low after DONE.
- Fixed period: sig_in with period 5 (high 2, low 3), WIN=10 -> total=50, min_per=max_per=5. A second start gives identical results, and the outputs hold 50/5/5 between runs.
- Stuck input: sig_in held low, start -> done_vld exactly 255 cycles after entering ARM, timeout=1, total=0, min_per=255, max_per=0.
- Stall mid-run: period 6 for 4 periods, then sig_in stops -> timeout=1, total=24, min_per=max_per=6.
- Control edges:
  - start pulsed during MEAS -> no effect; a single done_vld and correct totals.
  - start coincident with a detected edge -> first period measured from the following edge.
- Reset mid-MEAS: rst_n low for 2 cycles -> all outputs 0, no done_vld. A following start with period 7 -> total=70, min_per=max_per=7.
